// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-aware round-robin arbiter sharing one AXI-Stream sink among NUM_SRC sources.
// Define AXIS_ARB_STATS_EN to add per-source completed-packet counters on pkt_cnt.
//
//   state | meaning
//   IDLE  | no grant held; pick next requester round-robin from last_gnt+1
//   XFER  | grant held on gnt, beats pass through until its TLAST is accepted
module axis_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16,
  localparam int ID_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      s_aclk,
  input  logic                      s_resetn,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic                      m_tvalid,
  output logic [DATA_W-1:0]         m_tdata,
  output logic                      m_tlast,
  output logic [ID_W-1:0]           m_tid,
  input  logic                      m_tready,
  output logic                      busy
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [NUM_SRC*CNT_W-1:0]  pkt_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   gnt, gnt_nxt;
  logic [ID_W-1:0]   last_gnt, last_gnt_nxt;
  logic [ID_W-1:0]   winner;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              pkt_end;

  // Scan from the farthest offset down so the nearest requester after last_gnt wins.
  always_comb begin : rr_pick
    int idx;
    idx    = 0;
    winner = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last_gnt) + k) % NUM_SRC;
      if (s_tvalid[idx[ID_W-1:0]]) winner = idx[ID_W-1:0];
    end
  end

  always_comb begin : gnt_mux
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt == ID_W'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_data  = s_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin : fsm_comb
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    s_tready     = '0;
    m_tvalid     = 1'b0;
    m_tdata      = '0;
    m_tlast      = 1'b0;
    m_tid        = gnt;
    busy         = 1'b0;
    pkt_end      = 1'b0;
    case (state)
      IDLE: begin
        if (|s_tvalid) begin
          gnt_nxt   = winner;
          state_nxt = XFER;
        end
      end
      XFER: begin
        busy     = 1'b1;
        m_tvalid = sel_valid;
        m_tdata  = sel_data;
        m_tlast  = sel_last;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (gnt == ID_W'(i)) s_tready[i] = m_tready;
        end
        if (sel_valid && m_tready && sel_last) begin
          pkt_end      = 1'b1;
          state_nxt    = IDLE;
          last_gnt_nxt = gnt;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are forced quiet while reset is held, even before the first reset edge lands.
    if (!s_resetn) begin
      s_tready = '0;
      m_tvalid = 1'b0;
      m_tdata  = '0;
      m_tlast  = 1'b0;
      m_tid    = '0;
      busy     = 1'b0;
      pkt_end  = 1'b0;
    end
  end

  always_ff @(posedge s_aclk) begin
    if (!s_resetn) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= ID_W'(NUM_SRC - 1);
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

`ifdef AXIS_ARB_STATS_EN
  always_ff @(posedge s_aclk) begin
    if (!s_resetn) begin
      pkt_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pkt_end && gnt == ID_W'(i))
          pkt_cnt[i*CNT_W +: CNT_W] <= pkt_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: scoreboard bench for axis_rr_arbiter (4 sources, 8-bit data).
// Source beat FIFOs drive the inputs; expected output beats are queued in predicted grant order.
module tb_axis_rr_arbiter;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int CW = 16;

  logic             s_aclk   = 1'b0;
  logic             s_resetn = 1'b0;
  logic [NS-1:0]    s_tvalid = '0;
  logic [NS*DW-1:0] s_tdata  = '0;
  logic [NS-1:0]    s_tlast  = '0;
  logic [NS-1:0]    s_tready;
  logic             m_tvalid;
  logic [DW-1:0]    m_tdata;
  logic             m_tlast;
  logic [IW-1:0]    m_tid;
  logic             m_tready = 1'b1;
  logic             busy;
`ifdef AXIS_ARB_STATS_EN
  logic [NS*CW-1:0] pkt_cnt;
`endif

  int vec    = 0;
  int miscmp = 0;

  logic [8:0]    src_mem [NS][64];
  int            src_wr [NS];
  int            src_rd [NS];
  logic [NS-1:0] hold = '0;
  logic [NS-1:0] acc  = '0;
  logic [10:0]   exp_q [$];
  logic [10:0]   mon_exp;

  axis_rr_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .CNT_W(CW)) dut (
    .s_aclk   (s_aclk),
    .s_resetn (s_resetn),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tready (m_tready),
    .busy     (busy)
`ifdef AXIS_ARB_STATS_EN
    ,
    .pkt_cnt  (pkt_cnt)
`endif
  );

  always #5 s_aclk = ~s_aclk;

  task automatic drive_srcs();
    for (int i = 0; i < NS; i++) begin
      if (src_rd[i] != src_wr[i] && !hold[i]) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = src_mem[i][src_rd[i] % 64][7:0];
        s_tlast[i]           = src_mem[i][src_rd[i] % 64][8];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int src, input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      logic       lst;
      logic [7:0] d;
      lst = (b == n - 1);
      d   = base + 8'(b);
      src_mem[src][src_wr[src] % 64] = {lst, d};
      src_wr[src]++;
    end
    drive_srcs();
  endtask

  task automatic expect_beats(input int src, input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      logic [IW-1:0] t;
      logic          lst;
      logic [7:0]    d;
      t   = IW'(src);
      lst = (b == n - 1);
      d   = base + 8'(b);
      exp_q.push_back({t, lst, d});
    end
  endtask

  task automatic tick();
    @(posedge s_aclk);
    #2;
  endtask

  task automatic drain(input int max_cyc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cyc) begin
      tick();
      c++;
    end
    vec++;
    if (exp_q.size() != 0) begin
      miscmp++;
      $display("FAIL drain_timeout: %0d beats still outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  // Source side: pop a beat after each edge on which it was accepted, then re-present.
  always begin
    @(posedge s_aclk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) src_rd[i]++;
    end
    acc = '0;
    drive_srcs();
  end

  // Sink side: every accepted output beat must be the next expected one.
  always @(negedge s_aclk) begin
    acc = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      vec++;
      if (exp_q.size() == 0) begin
        miscmp++;
        $display("FAIL sb_unexpected: got tid=%0d last=%b data=%h, required no beat",
                 m_tid, m_tlast, m_tdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({m_tid, m_tlast, m_tdata} !== mon_exp) begin
          miscmp++;
          $display("FAIL sb_beat: got tid=%0d last=%b data=%h, required tid=%0d last=%b data=%h",
                   m_tid, m_tlast, m_tdata, mon_exp[10:9], mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic test_reset();
    s_resetn = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < NS; i++) push_pkt(i, 8'hA0 + 8'(i), 1);
    for (int i = 0; i < NS; i++) expect_beats(i, 8'hA0 + 8'(i), 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge s_aclk);
      vec++;
      if ({s_tready, m_tvalid, m_tdata, m_tlast, m_tid, busy} !== '0 || s_tvalid !== 4'hF) begin
        miscmp++;
        $display("FAIL reset_outputs: got s_tready=%b m_tvalid=%b m_tdata=%h m_tlast=%b m_tid=%0d busy=%b, required all 0",
                 s_tready, m_tvalid, m_tdata, m_tlast, m_tid, busy);
      end
      tick();
    end
    s_resetn = 1'b1;
    tick();
    @(negedge s_aclk);
    vec++;
    if ({busy, m_tid} !== {1'b1, 2'd0}) begin
      miscmp++;
      $display("FAIL reset_first_grant: got busy=%b m_tid=%0d, required busy=1 m_tid=0", busy, m_tid);
    end
    drain(50);
  endtask

  task automatic test_single_source();
    logic exp_b;
    push_pkt(2, 8'h21, 3);
    push_pkt(2, 8'h2B, 1);
    expect_beats(2, 8'h21, 3);
    expect_beats(2, 8'h2B, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge s_aclk);
      exp_b = (k != 3);
      vec++;
      if ({busy, m_tvalid} !== {exp_b, exp_b} || (exp_b && m_tid !== 2'd2)) begin
        miscmp++;
        $display("FAIL single_src_cycle%0d: got busy=%b m_tvalid=%b m_tid=%0d, required busy=%b m_tvalid=%b m_tid=2",
                 k, busy, m_tvalid, m_tid, exp_b, exp_b);
      end
    end
    drain(50);
  endtask

  task automatic test_all_request();
    tick();
    s_resetn = 1'b0;
    tick();
    s_resetn = 1'b1;
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < 2; p++) push_pkt(s, 8'h30 + 8'(s * 16 + p * 4), 2);
    end
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < NS; s++) expect_beats(s, 8'h30 + 8'(s * 16 + p * 4), 2);
    end
    drain(200);
`ifdef AXIS_ARB_STATS_EN
    for (int i = 0; i < NS; i++) begin
      vec++;
      if (pkt_cnt[i*CW +: CW] !== 16'd2) begin
        miscmp++;
        $display("FAIL pkt_cnt_src%0d: got %0d, required 2", i, pkt_cnt[i*CW +: CW]);
      end
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [NS-1:0] exp_tr;
    push_pkt(1, 8'h40, 4);
    expect_beats(1, 8'h40, 4);
    tick();
    for (int c = 0; c < 7; c++) begin
      m_tready = (c % 2 == 0);
      @(negedge s_aclk);
      exp_tr    = '0;
      exp_tr[1] = m_tready;
      vec++;
      if (s_tready !== exp_tr || busy !== 1'b1) begin
        miscmp++;
        $display("FAIL backpressure_c%0d: got s_tready=%b busy=%b, required s_tready=%b busy=1",
                 c, s_tready, busy, exp_tr);
      end
      tick();
    end
    m_tready = 1'b1;
    vec++;
    if (exp_q.size() != 0) begin
      miscmp++;
      $display("FAIL backpressure_done: got %0d beats outstanding, required 0", exp_q.size());
    end
    drain(20);
  endtask

  task automatic test_valid_drop();
    push_pkt(3, 8'hD0, 4);
    push_pkt(0, 8'hE0, 2);
    expect_beats(3, 8'hD0, 4);
    expect_beats(0, 8'hE0, 2);
    tick();
    tick();
    hold[3] = 1'b1;
    drive_srcs();
    for (int c = 0; c < 3; c++) begin
      @(negedge s_aclk);
      vec++;
      if ({m_tvalid, busy, m_tid, s_tready} !== {1'b0, 1'b1, 2'd3, 4'b1000}) begin
        miscmp++;
        $display("FAIL valid_drop_c%0d: got m_tvalid=%b busy=%b m_tid=%0d s_tready=%b, required 0 1 3 1000",
                 c, m_tvalid, busy, m_tid, s_tready);
      end
      tick();
    end
    hold[3] = 1'b0;
    drive_srcs();
    drain(50);
  endtask

  task automatic test_reset_mid_packet();
    push_pkt(2, 8'hF0, 4);
    exp_q.push_back({2'd2, 1'b0, 8'hF0});
    tick();
    tick();
    s_resetn = 1'b0;
    @(negedge s_aclk);
    vec++;
    if ({s_tready, m_tvalid, m_tdata, m_tlast, m_tid, busy} !== '0) begin
      miscmp++;
      $display("FAIL reset_mid_assert: got s_tready=%b m_tvalid=%b m_tdata=%h busy=%b, required all 0",
               s_tready, m_tvalid, m_tdata, busy);
    end
    tick();
    for (int i = 0; i < NS; i++) src_rd[i] = src_wr[i];
    drive_srcs();
    s_resetn = 1'b1;
    @(negedge s_aclk);
    vec++;
    if ({s_tready, m_tvalid, m_tdata, m_tlast, busy} !== '0) begin
      miscmp++;
      $display("FAIL reset_mid_idle: got s_tready=%b m_tvalid=%b m_tdata=%h busy=%b, required all 0",
               s_tready, m_tvalid, m_tdata, busy);
    end
    tick();
    push_pkt(2, 8'h72, 1);
    push_pkt(1, 8'h71, 1);
    push_pkt(0, 8'h70, 1);
    expect_beats(0, 8'h70, 1);
    expect_beats(1, 8'h71, 1);
    expect_beats(2, 8'h72, 1);
    drain(50);
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_all_request();
    test_backpressure();
    test_valid_drop();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
